// File: rtl/ex_mdu_seq_if.sv
// Execute-stage <-> M-unit signal bundle: instruction/operands in, stall and result out.
// The pipeline side uses the master modport, the sequencer uses the slave modport.
interface ex_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic            flush;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            is_md;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output valid_in, flush, opcode, funct3, funct7, data1, data2,
    input  is_md, stall, result_valid, result
  );

  modport slave (
    input  valid_in, flush, opcode, funct3, funct7, data1, data2,
    output is_md, stall, result_valid, result
  );
endinterface

// File: rtl/ex_mdu_seq.sv
// Multi-cycle RV32M sequencer: iterative shift-add multiply and restoring divide on magnitudes.
// Define EX_MDU_FAST_MUL_EN to resolve multiplies in one cycle with a combinational multiplier.
module ex_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic         clk,
  input logic         rst,
  ex_mdu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            accept, sgn_a, sgn_b, neg_a_in, neg_b_in, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign bus.is_md = (bus.opcode == 7'b0110011) && (bus.funct7 == 7'b0000001);
  assign accept    = (state_q == IDLE) && bus.valid_in && bus.is_md && !bus.flush && !rst;

  // Signed operands: rs1 for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM.
  assign sgn_a    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign sgn_b    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign neg_a_in = sgn_a && bus.data1[XLEN-1];
  assign neg_b_in = sgn_b && bus.data2[XLEN-1];
  assign mag_a    = neg_a_in ? -bus.data1 : bus.data1;
  assign mag_b    = neg_b_in ? -bus.data2 : bus.data2;
  assign div_zero = (bus.data2 == '0);
  assign div_ovf  = sgn_b && (bus.data1 == MIN_NEG) && (bus.data2 == '1);

  // One iteration step. acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_r, div_diff;
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quo, rem, fixed;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_r - {1'b0, b_q};
  assign step_acc = f3_q[2]
                  ? {(div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc_q[XLEN-2:0], ~div_diff[XLEN]}
                  : {mul_sum, acc_q[XLEN-1:1]};

  assign prod  = (neg_a_q ^ neg_b_q) ? -step_acc : step_acc;
  assign quo   = (neg_a_q ^ neg_b_q) ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
  assign rem   = neg_a_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
  assign fixed = f3_q[2] ? (f3_q[1] ? rem : quo)
                         : ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

`ifdef EX_MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
  assign fast_a    = {neg_a_in, bus.data1};
  assign fast_b    = {neg_b_in, bus.data2};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path leaves a latch behind.
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d    = bus.funct3;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          b_d     = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          cnt_d   = '0;
          state_d = BUSY;
          if (bus.funct3[2] && div_zero) begin
            state_d  = DONE;
            result_d = bus.funct3[1] ? bus.data1 : '1;
          end else if (bus.funct3[2] && div_ovf) begin
            state_d  = DONE;
            result_d = bus.funct3[1] ? '0 : bus.data1;
          end
`ifdef EX_MDU_FAST_MUL_EN
          else if (!bus.funct3[2]) begin
            state_d  = DONE;
            result_d = (bus.funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                  : fast_prod[2*XLEN-1:XLEN];
          end
`endif
        end
      end
      BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d  = DONE;
          result_d = fixed;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.stall        = accept || (state_q == BUSY);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = result_q;

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Self-checking bench for ex_mdu_seq: directed RV32M cases plus randomized ops against an
// arithmetic reference model; multiply latency follows EX_MDU_FAST_MUL_EN.
module tb_ex_mdu_seq;

  localparam int XLEN = 32;
`ifdef EX_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int unsigned cyc_now = 0;

  ex_mdu_seq_if #(.XLEN(XLEN)) bus ();

  ex_mdu_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = 1'b1;
    bus.flush    = 1'b0;
    bus.opcode   = 7'b0110011;
    bus.funct7   = 7'b0000001;
    bus.funct3   = f3;
    bus.data1    = a;
    bus.data2    = b;
  endtask

  // Counts stall-high cycles until result_valid, bounded by a cycle budget.
  task automatic wait_result(input int lat0, output int lat, output logic [31:0] res,
                             output logic st_done, output bit ok);
    lat = lat0; ok = 1'b0; res = 'x; st_done = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.result_valid) begin
        res = bus.result; st_done = bus.stall; ok = 1'b1;
        break;
      end
      if (bus.stall) lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic st_done, output bit ok);
    @(negedge clk);
    drive(f3, a, b);
    #1;
    wait_result(bus.stall ? 1 : 0, lat, res, st_done, ok);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] res; logic st; bit ok;
    drive(3'd0, 32'd3, 32'd5);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else n_pass++;
      n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL reset_rv: got %b want 0", bus.result_valid); else n_pass++;
      n_checks++; if (bus.result !== 32'd0) $display("FAIL reset_result: got %h want 0", bus.result); else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b1) $display("FAIL reset_accept_stall: got %b want 1", bus.stall); else n_pass++;
    wait_result(1, lat, res, st, ok);
    n_checks++; if (!ok || res !== 32'd15) $display("FAIL reset_first_mul: got %h want 0000000f", res); else n_pass++;
    n_checks++; if (lat !== MUL_LAT) $display("FAIL reset_first_lat: got %0d want %0d", lat, MUL_LAT); else n_pass++;
    go_idle();
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; logic st; bit ok;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFA, lat, res, st, ok);
    n_checks++; if (!ok || res !== 32'hFFFF_FFD6) $display("FAIL mul_result: got %h want ffffffd6", res); else n_pass++;
    n_checks++; if (lat !== MUL_LAT) $display("FAIL mul_lat: got %0d want %0d", lat, MUL_LAT); else n_pass++;
    n_checks++; if (st !== 1'b0) $display("FAIL mul_done_stall: got %b want 0", st); else n_pass++;
    go_idle();
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] exps[3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    int lat; logic [31:0] res; logic st; bit ok;
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], 32'h8000_0000, 32'hFFFF_FFFF, lat, res, st, ok);
      n_checks++; if (!ok || res !== exps[i]) $display("FAIL mulh_f3_%0d: got %h want %h", f3s[i], res, exps[i]); else n_pass++;
      go_idle();
    end
  endtask

  task automatic test_div();
    logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0001};
    int lat; logic [31:0] res; logic st; bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(3'(4 + i), 32'hFFFF_FFF9, 32'd2, lat, res, st, ok);
      n_checks++; if (!ok || res !== exps[i]) $display("FAIL div_f3_%0d: got %h want %h", 4 + i, res, exps[i]); else n_pass++;
      n_checks++; if (lat !== DIV_LAT) $display("FAIL div_lat_f3_%0d: got %0d want %0d", 4 + i, lat, DIV_LAT); else n_pass++;
      go_idle();
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] res; logic st; bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], lat, res, st, ok);
      n_checks++; if (!ok || res !== exps[i]) $display("FAIL special_%0d: got %h want %h", i, res, exps[i]); else n_pass++;
      n_checks++; if (lat !== 1) $display("FAIL special_lat_%0d: got %0d want 1", i, lat); else n_pass++;
      go_idle();
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b, e; logic st; bit ok; logic [2:0] f3; int sel;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($signed($urandom_range(0, 40)) - 20); b = 32'($signed($urandom_range(0, 16)) - 8); end
      e = model(f3, a, b);
      run_op(f3, a, b, lat, res, st, ok);
      n_checks++; if (!ok || res !== e) $display("FAIL rand_%0d f3=%0d a=%h b=%h: got %h want %h", i, f3, a, b, res, e); else n_pass++;
      n_checks++; if (lat !== exp_lat(f3, a, b)) $display("FAIL rand_lat_%0d: got %0d want %0d", i, lat, exp_lat(f3, a, b)); else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; logic st; bit ok; bit seen;
    @(negedge clk);
    drive(3'd4, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.valid_in = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL flush_busy_stall: got %b want 0", bus.stall); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); #1; if (bus.result_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_busy_no_result: got %b want 0", seen); else n_pass++;
    @(negedge clk);
    drive(3'd0, 32'd2, 32'd3);
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL flush_accept_stall: got %b want 0", bus.stall); else n_pass++;
    go_idle();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); #1; if (bus.result_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_accept_no_result: got %b want 0", seen); else n_pass++;
    run_op(3'd4, 32'd5, 32'd0, lat, res, st, ok);
    bus.flush = 1'b1;
    #1;
    n_checks++; if (!ok || bus.result_valid !== 1'b1) $display("FAIL flush_done_rv: got %b want 1", bus.result_valid); else n_pass++;
    go_idle();
    #1;
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL flush_done_after: got %b want 0", bus.result_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] r1, r2; logic st; bit ok1, ok2; int unsigned t1, t2;
    run_op(3'd0, 32'd3, 32'd9, lat1, r1, st, ok1);
    t1 = cyc_now;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd5, lat2, r2, st, ok2);
    t2 = cyc_now;
    n_checks++; if (!ok1 || r1 !== 32'd27) $display("FAIL b2b_first: got %h want 0000001b", r1); else n_pass++;
    n_checks++; if (!ok2 || r2 !== 32'hFFFF_FFF6) $display("FAIL b2b_second: got %h want fffffff6", r2); else n_pass++;
    n_checks++; if (lat2 !== MUL_LAT) $display("FAIL b2b_accept_lat: got %0d want %0d", lat2, MUL_LAT); else n_pass++;
    n_checks++; if (t2 - t1 !== MUL_LAT + 1) $display("FAIL b2b_gap: got %0d want %0d", t2 - t1, MUL_LAT + 1); else n_pass++;
    go_idle();
  endtask

  task automatic test_non_m();
    bit seen;
    @(negedge clk);
    bus.valid_in = 1'b1; bus.opcode = 7'b0110011; bus.funct7 = 7'b0000000; bus.funct3 = 3'd0;
    #1;
    n_checks++; if (bus.is_md !== 1'b0 || bus.stall !== 1'b0) $display("FAIL nonm_add: got is_md=%b stall=%b want 0/0", bus.is_md, bus.stall); else n_pass++;
    bus.opcode = 7'b0010011; bus.funct7 = 7'b0000001;
    #1;
    n_checks++; if (bus.is_md !== 1'b0) $display("FAIL nonm_opimm: got %b want 0", bus.is_md); else n_pass++;
    bus.valid_in = 1'b0; bus.opcode = 7'b0110011;
    #1;
    n_checks++; if (bus.is_md !== 1'b1 || bus.stall !== 1'b0) $display("FAIL nonm_bubble: got is_md=%b stall=%b want 1/0", bus.is_md, bus.stall); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; if (bus.result_valid || bus.stall) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL nonm_quiet: got %b want 0", seen); else n_pass++;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    drive(3'd5, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.valid_in = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL rstmid_rv: got %b want 0", bus.result_valid); else n_pass++;
    n_checks++; if (bus.result !== 32'd0) $display("FAIL rstmid_result: got %h want 0", bus.result); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.valid_in = 1'b0; bus.flush = 1'b0; bus.opcode = '0; bus.funct3 = '0;
    bus.funct7 = '0; bus.data1 = '0; bus.data2 = '0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_back_to_back();
    test_non_m();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
